// File: rtl/time_arb_2ch.sv
// Two-channel record arbiter: grants whole records oldest-timestamp-first from per-channel timestamp queues.
// Optional per-channel record counters are enabled by defining TIME_ARB_STATS_EN.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// IDLE (0)    | wait for a non-empty queue with downstream ready, then grant
// RDn (1..N)  | pop beat n of the granted record (N = REC_BEATS)
module time_arb_2ch #(
    parameter int TSQ_DEPTH = 8,
    parameter int REC_BEATS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] iCH0_DATA,
    input  logic [127:0] iCH1_DATA,
    input  logic         iCH0_GTS_VALID,
    input  logic         iCH1_GTS_VALID,
    input  logic [55:0]  iCH0_GOOD_TS,
    input  logic [55:0]  iCH1_GOOD_TS,
    output logic         oCH0_READ,
    output logic         oCH1_READ,
    input  logic         iDST_AFULL,
    output logic [127:0] oARB_DATA,
    output logic         oARB_VALID,
    output logic         oARB_SOP,
    output logic         oARB_EOP,
    output logic         oARB_CHNL,
    output logic         oTSQ0_OVF,
    output logic         oTSQ1_OVF
`ifdef TIME_ARB_STATS_EN
    ,
    output logic [31:0]  oCH0_REC_CNT,
    output logic [31:0]  oCH1_REC_CNT
`endif
);

    localparam int PW = (TSQ_DEPTH > 1) ? $clog2(TSQ_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = $clog2(REC_BEATS + 1);
    localparam logic [SW-1:0] ST_IDLE = '0;
    localparam logic [SW-1:0] ST_RD1  = SW'(1);
    localparam logic [SW-1:0] ST_LAST = SW'(REC_BEATS);
    localparam logic [CW-1:0] FULL_CNT = CW'(TSQ_DEPTH);

    logic [SW-1:0] state, stateNext;
    logic          grant, pick1, inRd;
    logic [1:0]    gtsValid, elig, pushOk, pop, chRead, tsOvf;
    logic [55:0]   goodTs [2];
    logic [55:0]   head [2];
    logic [55:0]   tsMem [2][TSQ_DEPTH];
    logic [PW-1:0] wrPtr [2];
    logic [PW-1:0] rdPtr [2];
    logic [CW-1:0] tsCnt [2];

    assign gtsValid  = {iCH1_GTS_VALID, iCH0_GTS_VALID};
    assign goodTs[0] = iCH0_GOOD_TS;
    assign goodTs[1] = iCH1_GOOD_TS;

    always_comb begin
        elig   = '0;
        pushOk = '0;
        for (int c = 0; c < 2; c++) begin
            head[c]   = tsMem[c][rdPtr[c]];
            elig[c]   = (tsCnt[c] != '0);
            // a full queue drops the push even if it is popped in the same cycle
            pushOk[c] = gtsValid[c] && (tsCnt[c] != FULL_CNT);
        end
    end

    // ties go to channel 0
    assign pick1 = elig[1] && (!elig[0] || (head[1] < head[0]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        if (state == ST_IDLE) begin
            if (!iDST_AFULL && (elig != 2'b00)) stateNext = ST_RD1;
        end else if (state == ST_LAST) begin
            stateNext = ST_IDLE;
        end else begin
            stateNext = state + SW'(1);
        end
    end

    always_comb begin
        inRd   = (state != ST_IDLE);
        chRead = inRd ? (grant ? 2'b10 : 2'b01) : 2'b00;
        pop    = (state == ST_RD1) ? chRead : 2'b00;
    end

    assign oCH0_READ = chRead[0];
    assign oCH1_READ = chRead[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                         grant <= 1'b0;
        else if ((state == ST_IDLE) && (stateNext == ST_RD1)) grant <= pick1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                wrPtr[c] <= '0;
                rdPtr[c] <= '0;
                tsCnt[c] <= '0;
            end
            tsOvf <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (pushOk[c]) wrPtr[c] <= wrPtr[c] + PW'(1);
                if (pop[c])    rdPtr[c] <= rdPtr[c] + PW'(1);
                tsCnt[c] <= tsCnt[c] + CW'(pushOk[c]) - CW'(pop[c]);
                if (gtsValid[c] && !pushOk[c]) tsOvf[c] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (pushOk[c]) tsMem[c][wrPtr[c]] <= goodTs[c];
        end
    end

    assign oTSQ0_OVF = tsOvf[0];
    assign oTSQ1_OVF = tsOvf[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oARB_VALID <= 1'b0;
            oARB_SOP   <= 1'b0;
            oARB_EOP   <= 1'b0;
            oARB_CHNL  <= 1'b0;
        end else begin
            oARB_VALID <= inRd;
            oARB_SOP   <= (state == ST_RD1);
            oARB_EOP   <= (state == ST_LAST);
            oARB_CHNL  <= inRd & grant;
        end
    end

    always_ff @(posedge clk) begin
        if (inRd) oARB_DATA <= grant ? iCH1_DATA : iCH0_DATA;
    end

`ifdef TIME_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oCH0_REC_CNT <= '0;
            oCH1_REC_CNT <= '0;
        end else begin
            if (pop[0]) oCH0_REC_CNT <= oCH0_REC_CNT + 32'd1;
            if (pop[1]) oCH1_REC_CNT <= oCH1_REC_CNT + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_time_arb_2ch.sv
// Bench for time_arb_2ch: directed vector table, multi-cycle corner sequences, then random traffic vs a queue model.
module tb_time_arb_2ch;

    localparam int RB    = 4;
    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] d0, d1;
    logic         g0, g1;
    logic [55:0]  t0, t1;
    logic         afull;
    logic         rd0, rd1;
    logic [127:0] arbData;
    logic         arbValid, arbSop, arbEop, arbChnl;
    logic         ovf0, ovf1;
`ifdef TIME_ARB_STATS_EN
    logic [31:0]  cnt0, cnt1;
`endif

    int nChk = 0;
    int nErr = 0;

    always #5 clk = ~clk;

    time_arb_2ch #(.TSQ_DEPTH(DEPTH), .REC_BEATS(RB)) dut (
        .clk(clk), .rst_n(rst_n),
        .iCH0_DATA(d0), .iCH1_DATA(d1),
        .iCH0_GTS_VALID(g0), .iCH1_GTS_VALID(g1),
        .iCH0_GOOD_TS(t0), .iCH1_GOOD_TS(t1),
        .oCH0_READ(rd0), .oCH1_READ(rd1),
        .iDST_AFULL(afull),
        .oARB_DATA(arbData), .oARB_VALID(arbValid), .oARB_SOP(arbSop),
        .oARB_EOP(arbEop), .oARB_CHNL(arbChnl),
        .oTSQ0_OVF(ovf0), .oTSQ1_OVF(ovf1)
`ifdef TIME_ARB_STATS_EN
        , .oCH0_REC_CNT(cnt0), .oCH1_REC_CNT(cnt1)
`endif
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nChk++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic waitRead(input int ch, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = (ch == 1) ? rd1 : rd0;
        end
        chk("wait_read", 128'(seen), 128'd1);
    endtask

    function automatic logic [55:0] randTs();
        logic [63:0] w;
        w = {$urandom(), $urandom()};
        if ($urandom_range(0, 3) == 0) return 56'($urandom_range(0, 7));
        return w[55:0];
    endfunction

    // exp = {read0, read1, valid, sop, eop, chnl}
    typedef struct {
        logic        push;
        logic [55:0] ts0;
        logic [55:0] ts1;
        logic [5:0]  exp;
    } vec_t;

    vec_t tbl [24];

    logic [55:0]  q0[$], q1[$];
    int           mBeat, mCh;
    logic         mValid, mSop, mEop, mChnl, mOvf0, mOvf1;
    logic [127:0] mData;

    initial begin
        int r0c, r1c, sopc, vc;
        tbl = '{
            '{1'b1, 56'h100, 56'h080, 6'b000000},
            '{1'b0, 56'h0,   56'h0,   6'b000000},
            '{1'b0, 56'h0,   56'h0,   6'b010000},
            '{1'b0, 56'h0,   56'h0,   6'b011101},
            '{1'b0, 56'h0,   56'h0,   6'b011001},
            '{1'b0, 56'h0,   56'h0,   6'b011001},
            '{1'b0, 56'h0,   56'h0,   6'b001011},
            '{1'b0, 56'h0,   56'h0,   6'b100000},
            '{1'b0, 56'h0,   56'h0,   6'b101100},
            '{1'b0, 56'h0,   56'h0,   6'b101000},
            '{1'b0, 56'h0,   56'h0,   6'b101000},
            '{1'b1, 56'h200, 56'h200, 6'b001010},
            '{1'b0, 56'h0,   56'h0,   6'b000000},
            '{1'b0, 56'h0,   56'h0,   6'b100000},
            '{1'b0, 56'h0,   56'h0,   6'b101100},
            '{1'b0, 56'h0,   56'h0,   6'b101000},
            '{1'b0, 56'h0,   56'h0,   6'b101000},
            '{1'b0, 56'h0,   56'h0,   6'b001010},
            '{1'b0, 56'h0,   56'h0,   6'b010000},
            '{1'b0, 56'h0,   56'h0,   6'b011101},
            '{1'b0, 56'h0,   56'h0,   6'b011001},
            '{1'b0, 56'h0,   56'h0,   6'b011001},
            '{1'b0, 56'h0,   56'h0,   6'b001011},
            '{1'b0, 56'h0,   56'h0,   6'b000000}
        };

        rst_n = 1'b0; g0 = 0; g1 = 0; t0 = '0; t1 = '0; afull = 0;
        d0 = {4{32'hA0A0_0000}}; d1 = {4{32'hB1B1_1111}};
        repeat (2) @(negedge clk);
        chk("rst_read", 128'({rd0, rd1}), 128'd0);
        chk("rst_out", 128'({arbValid, arbSop, arbEop, arbChnl}), 128'd0);
        chk("rst_ovf", 128'({ovf0, ovf1}), 128'd0);
        rst_n = 1'b1;

        // ordering by timestamp, tie to ch0, one-cycle gap
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            chk($sformatf("tbl%0d", i), 128'({rd0, rd1, arbValid, arbSop, arbEop, arbChnl}), 128'(tbl[i].exp));
            if (tbl[i].exp[3]) chk($sformatf("tbl%0d_data", i), arbData, tbl[i].exp[0] ? d1 : d0);
            g0 = tbl[i].push; g1 = tbl[i].push; t0 = tbl[i].ts0; t1 = tbl[i].ts1;
        end
        @(negedge clk); g0 = 0; g1 = 0;

        // almost-full raised mid-record
        @(negedge clk); g0 = 1; t0 = 56'd5; g1 = 1; t1 = 56'd6;
        @(negedge clk); g0 = 0; g1 = 0;
        waitRead(0, 10);
        @(negedge clk); afull = 1;
        r0c = 0; r1c = 0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            r0c += int'(rd0); r1c += int'(rd1);
        end
        chk("afull_finish_ch0", 128'(r0c), 128'd3);
        chk("afull_hold_ch1", 128'(r1c), 128'd0);
        afull = 0;
        r0c = 0; r1c = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            r0c += int'(rd0); r1c += int'(rd1);
        end
        chk("afull_release_ch1", 128'(r1c), 128'd4);
        chk("afull_release_ch0", 128'(r0c), 128'd0);

        // overflow: nine pushes into an eight-deep queue
        afull = 1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); g0 = 1; t0 = 56'(i + 16);
        end
        @(negedge clk); g0 = 0;
        @(negedge clk);
        chk("ovf0_set", 128'(ovf0), 128'd1);
        chk("ovf1_clear", 128'(ovf1), 128'd0);
        afull = 0;
        r0c = 0; sopc = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            r0c += int'(rd0); sopc += int'(arbSop);
        end
        chk("ovf_drain_beats", 128'(r0c), 128'd32);
        chk("ovf_drain_recs", 128'(sopc), 128'd8);
        chk("ovf0_sticky", 128'(ovf0), 128'd1);

        // reset pulse during RD3 with ch0 still queued
        @(negedge clk); g0 = 1; t0 = 56'd2; g1 = 1; t1 = 56'd1;
        @(negedge clk); g0 = 0; g1 = 0;
        waitRead(1, 10);
        @(negedge clk);
        @(negedge clk);
        chk("rd3_active", 128'(rd1), 128'd1);
        rst_n = 0;
        @(negedge clk);
        chk("midrst_read", 128'({rd0, rd1}), 128'd0);
        chk("midrst_out", 128'({arbValid, arbSop, arbEop, arbChnl}), 128'd0);
        chk("midrst_ovf", 128'({ovf0, ovf1}), 128'd0);
        rst_n = 1;
        r0c = 0; vc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            r0c += int'(rd0) + int'(rd1); vc += int'(arbValid);
        end
        chk("postrst_reads", 128'(r0c), 128'd0);
        chk("postrst_valid", 128'(vc), 128'd0);

        // random traffic against the queue model
        q0.delete(); q1.delete();
        mBeat = 0; mCh = 0; mValid = 0; mSop = 0; mEop = 0; mChnl = 0; mData = '0;
        mOvf0 = 0; mOvf1 = 0;
        for (int n = 0; n < 3000; n++) begin
            int sz0, sz1, cur;
            @(negedge clk);
            chk("rnd_read0", 128'(rd0), 128'(mBeat != 0 && mCh == 0));
            chk("rnd_read1", 128'(rd1), 128'(mBeat != 0 && mCh == 1));
            chk("rnd_valid", 128'(arbValid), 128'(mValid));
            if (mValid) begin
                chk("rnd_sop_eop_chnl", 128'({arbSop, arbEop, arbChnl}), 128'({mSop, mEop, mChnl}));
                chk("rnd_data", arbData, mData);
            end
            chk("rnd_ovf", 128'({ovf0, ovf1}), 128'({mOvf0, mOvf1}));

            g0 = ($urandom_range(0, 7) == 0); t0 = randTs();
            g1 = ($urandom_range(0, 7) == 0); t1 = randTs();
            afull = ($urandom_range(0, 3) == 0);
            d0 = {$urandom(), $urandom(), $urandom(), $urandom()};
            d1 = {$urandom(), $urandom(), $urandom(), $urandom()};

            cur = mBeat;
            mValid = (cur != 0);
            mSop   = (cur == 1);
            mEop   = (cur == RB);
            mChnl  = (cur != 0) && (mCh == 1);
            if (cur != 0) mData = (mCh == 1) ? d1 : d0;
            sz0 = q0.size(); sz1 = q1.size();
            if (cur == 1) begin
                if (mCh == 1) void'(q1.pop_front());
                else          void'(q0.pop_front());
            end
            if (cur == 0) begin
                if (!afull && (sz0 > 0 || sz1 > 0)) begin
                    if (sz0 > 0 && sz1 > 0) mCh = (q1[0] < q0[0]) ? 1 : 0;
                    else                    mCh = (sz1 > 0) ? 1 : 0;
                    mBeat = 1;
                end
            end else begin
                mBeat = (cur == RB) ? 0 : cur + 1;
            end
            if (g0) begin
                if (sz0 == DEPTH) mOvf0 = 1; else q0.push_back(t0);
            end
            if (g1) begin
                if (sz1 == DEPTH) mOvf1 = 1; else q1.push_back(t1);
            end
        end
        @(negedge clk); g0 = 0; g1 = 0; afull = 0;

`ifdef TIME_ARB_STATS_EN
        rst_n = 0;
        @(negedge clk);
        chk("stats_rst", 128'({cnt0, cnt1}), 128'd0);
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            g0 = (i < 3); t0 = 56'(i * 4);
            g1 = (i >= 3); t1 = 56'(i * 4 + 1);
        end
        @(negedge clk); g0 = 0; g1 = 0;
        repeat (40) @(negedge clk);
        chk("stats_cnt0", 128'(cnt0), 128'd3);
        chk("stats_cnt1", 128'(cnt1), 128'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChk, nErr);
        $finish;
    end

endmodule
